// File: rtl/score_display_pkg.sv
// Shared types and constants for the score display multiplexer.
// State encoding, the 7-segment patterns (bit0=a .. bit6=g) and the
// digit-enable codes live here.
package score_display_pkg;

  typedef enum logic [1:0] {
    BLANK_T = 2'd0,
    SHOW_T  = 2'd1,
    BLANK_O = 2'd2,
    SHOW_O  = 2'd3
  } state_t;

  // Segment patterns, g..a
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;
  localparam logic [6:0] SEG_OFF  = 7'b0000000;

  // Digit enables: bit1 = tens, bit0 = ones
  localparam logic [1:0] DIG_TENS = 2'b10;
  localparam logic [1:0] DIG_ONES = 2'b01;
  localparam logic [1:0] DIG_NONE = 2'b00;

  // Non-BCD codes (10..15) show a dash so a bad upstream value is visible.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/score_display_mux_seg7_decode.sv
// seg7_decode: combinational BCD digit to 7-segment pattern (active-high).
module seg7_decode
  import score_display_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Pure table lookup
  always_comb begin
    o_seg = bcd_to_seg(i_bcd);
  end

endmodule

// File: rtl/score_display_mux.sv
// score_display_mux: drives a 2-digit multiplexed common-cathode display.
// Scan FSM BLANK_T -> SHOW_T -> BLANK_O -> SHOW_O, per-frame snapshot of the
// BCD digits, dark guard cycles at the start of each slot and optional
// leading-zero blanking of the tens digit.
// Optional macro SCORE_DISPLAY_BLINK_EN adds blink_i and a 5-bit frame counter
// that darkens the SHOW states for 16 of every 32 frames while blink_i=1.
// Outputs are registered from the next-cycle values, so they always match the
// state and latched digits of the cycle in which they are visible.
module score_display_mux
  import score_display_pkg::*;
#(
  parameter int SCAN_DIV     = 1024,
  parameter int BLANK_CYCLES = 4,
  parameter int LZB          = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] tens_i,
  input  logic [3:0] ones_i,
`ifdef SCORE_DISPLAY_BLINK_EN
  input  logic       blink_i,
`endif
  output logic [6:0] seg_o,
  output logic [1:0] dig_o,
  output logic       frame_o
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST       = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK_LAST = CW'(BLANK_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [3:0]    r_tens;
  logic [3:0]    r_ones;
  logic [3:0]    w_tens_next;
  logic [3:0]    w_ones_next;
  logic [3:0]    w_dec_in;
  logic [6:0]    w_dec_seg;
  logic [6:0]    r_seg;
  logic [6:0]    w_seg_next;
  logic [1:0]    r_dig;
  logic [1:0]    w_dig_next;
  logic          r_frame;
  logic          w_snap;
  logic          w_blink_dark;

  assign w_snap      = (r_state == BLANK_T) && (r_cnt == '0);
  assign w_tens_next = w_snap ? tens_i : r_tens;
  assign w_ones_next = w_snap ? ones_i : r_ones;
  assign w_cnt_next  = (r_cnt == CNT_LAST) ? '0 : r_cnt + CW'(1);

`ifdef SCORE_DISPLAY_BLINK_EN
  logic [4:0] r_fcnt;
  logic [4:0] w_fcnt_next;
  logic [4:0] w_frame_idx;

  // Frame counter advances once per snapshot
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_fcnt <= '0;
    else         r_fcnt <= w_fcnt_next;
  end

  assign w_fcnt_next  = w_snap ? r_fcnt + 5'd1 : r_fcnt;
  // The counter already includes the current frame's snapshot, so the
  // zero-based index of the frame on display is one less.
  assign w_frame_idx  = w_fcnt_next - 5'd1;
  assign w_blink_dark = blink_i & w_frame_idx[4];
`else
  assign w_blink_dark = 1'b0;
`endif

  // Next-state logic: blank slots hand over to show, show slots end the slot
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      BLANK_T: if (r_cnt == CNT_BLANK_LAST) w_state_next = SHOW_T;
      SHOW_T:  if (r_cnt == CNT_LAST)       w_state_next = BLANK_O;
      BLANK_O: if (r_cnt == CNT_BLANK_LAST) w_state_next = SHOW_O;
      SHOW_O:  if (r_cnt == CNT_LAST)       w_state_next = BLANK_T;
      default: w_state_next = BLANK_T;
    endcase
  end

  // Single shared decoder, fed with whichever digit the next cycle shows
  assign w_dec_in = (w_state_next == SHOW_T) ? w_tens_next : w_ones_next;

  seg7_decode u_decode (
    .i_bcd (w_dec_in),
    .o_seg (w_dec_seg)
  );

  // Output decode for the next cycle; blank slots and blink keep all dark
  always_comb begin
    w_seg_next = SEG_OFF;
    w_dig_next = DIG_NONE;
    case (w_state_next)
      SHOW_T: begin
        w_dig_next = DIG_TENS;
        w_seg_next = ((LZB != 0) && (w_tens_next == 4'd0)) ? SEG_OFF : w_dec_seg;
      end
      SHOW_O: begin
        w_dig_next = DIG_ONES;
        w_seg_next = w_dec_seg;
      end
      default: begin
        w_seg_next = SEG_OFF;
        w_dig_next = DIG_NONE;
      end
    endcase
    if (w_blink_dark) begin
      w_seg_next = SEG_OFF;
      w_dig_next = DIG_NONE;
    end
  end

  // State, slot counter, digit snapshot and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= BLANK_T;
      r_cnt   <= '0;
      r_tens  <= 4'd0;
      r_ones  <= 4'd0;
      r_seg   <= SEG_OFF;
      r_dig   <= DIG_NONE;
      r_frame <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_tens  <= w_tens_next;
      r_ones  <= w_ones_next;
      r_seg   <= w_seg_next;
      r_dig   <= w_dig_next;
      r_frame <= w_snap;
    end
  end

  assign seg_o   = r_seg;
  assign dig_o   = r_dig;
  assign frame_o = r_frame;

endmodule

// File: doc/score_display_mux.md
Name: score_display_mux

Overview:
- Downstream consumer of the binary-to-decimal stage.
- Takes the tens/ones BCD digits and drives a 2-digit time-multiplexed common-cathode 7-segment display: scan timing, per-frame snapshot, anti-ghosting blank, leading-zero blanking.
- Sits between the BCD converter and the top-level output pins.

Parameters:
- SCAN_DIV, 1024: clock cycles per digit slot. Must be ≥ 2.
- BLANK_CYCLES, 4: dark cycles at the start of each slot (ghost guard). Must satisfy 1 ≤ BLANK_CYCLES < SCAN_DIV.
- LZB, 1: when 1, a tens digit of 0 is blanked.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous reset, active-low
- tens_i  input  4  BCD tens digit from converter
- ones_i  input  4  BCD ones digit from converter
- seg_o  output  7  segments, active-high; bit0=a … bit6=g
- dig_o  output  2  digit enables, active-high; bit1=tens, bit0=ones
- frame_o  output  1  one-cycle strobe, asserted the cycle after each snapshot

Behaviour:
- Reset (rst_ni low, asynchronous):
  - seg_o=0, dig_o=0, frame_o=0
  - state=BLANK_T, slot counter=0, tens_q=0, ones_q=0
  - Takes effect immediately, without a clock edge.
- FSM states: BLANK_T → SHOW_T → BLANK_O → SHOW_O → BLANK_T.
  - Each BLANK_x lasts BLANK_CYCLES cycles.
  - Each SHOW_x lasts SCAN_DIV−BLANK_CYCLES cycles.
  - Frame = 2·SCAN_DIV cycles.
- Slot counter:
  - Width = clog2(SCAN_DIV).
  - Counts 0..SCAN_DIV−1 within the slot, then wraps to 0 on the slot change.
  - BLANK→SHOW transition occurs when counter == BLANK_CYCLES−1.
- Snapshot:
  - On every clock edge where state==BLANK_T and counter==0, capture tens_i/ones_i into tens_q/ones_q.
  - The first edge after reset release is a snapshot edge.
  - Input changes at any other time do not affect the display until the next snapshot.
- frame_o: registered; high for exactly one cycle following each snapshot edge.
- seg_o/dig_o:
  - Registered, glitch-free.
  - Always equal the decode of the current state and latched digits.
  - BLANK_x: dig_o=00, seg_o=0.
  - SHOW_T: dig_o=10, seg_o=dec(tens_q). If LZB=1 and tens_q==0, seg_o=0 while dig_o stays 10.
  - SHOW_O: dig_o=01, seg_o=dec(ones_q). Ones digit is never blanked.
- Decode table (g..a):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
  - Any value 10–15 → dash 1000000.
- dig_o is never 11 in any cycle.

Optional Feature:
- Macro: SCORE_DISPLAY_BLINK_EN.
- Defined:
  - Adds input blink_i (1 bit).
  - Adds a 5-bit frame counter, incremented on each snapshot edge, reset to 0.
  - While blink_i=1 and frame counter bit4=1, the SHOW states output dig_o=00, seg_o=0. Display is dark for 16 frames, lit for 16.
  - The FSM, snapshot and frame_o are unaffected.
- Undefined: no blink_i port, no frame counter; display is never blanked except by BLANK states and LZB.

Decomposition:
- Package score_display_pkg:
  - FSM state encoding (2-bit): BLANK_T=0, SHOW_T=1, BLANK_O=2, SHOW_O=3.
  - 7-bit segment constants for 0–9, SEG_DASH, SEG_OFF.
  - Digit-enable constants DIG_TENS=10, DIG_ONES=01, DIG_NONE=00.
- Sub-module seg7_decode: purely combinational 4-bit BCD → 7-bit segment map. Instantiated once, fed by a tens_q/ones_q mux selected by state.

Test Plan:
(SCAN_DIV=8, BLANK_CYCLES=2, LZB=1 unless noted)
1. Reset then release with tens_i=4, ones_i=2:
   - seg_o=0, dig_o=0 during reset.
   - frame_o=1 in the cycle after the first edge.
   - 2 dark cycles, then dig_o=10, seg_o=1100110 for 6 cycles.
   - 2 dark cycles, then dig_o=01, seg_o=1011011 for 6 cycles.
   - Period of 16 cycles repeats.
2. tens_i=0, ones_i=7:
   - SHOW_T: dig_o=10, seg_o=0.
   - SHOW_O: seg_o=0000111.
   - With LZB=0, SHOW_T gives seg_o=0111111.
3. Change tens_i 4→9 in mid-frame (during SHOW_O): display keeps 4 until the next frame_o, after which SHOW_T shows 1101111.
4. tens_i=4'hC, ones_i=4'hF: both digits show 1000000.
5. Assert rst_ni low mid-SHOW_O:
   - seg_o/dig_o/frame_o go 0 before the next clock edge.
   - After release, the sequence restarts at BLANK_T with a new snapshot.
6. With SCORE_DISPLAY_BLINK_EN and blink_i=1:
   - Frames 0–15 display normally.
   - Frames 16–31 keep dig_o=00 throughout while frame_o still pulses every 16 cycles.
